// File: rtl/event_unit_hw_barrier_if.sv
// Core-side and interconnect-side register bus of the hardware barrier.
// The barrier unit uses the slave modport; the bus driver uses the master modport.
interface event_unit_hw_barrier_if #(
    parameter int unsigned NB_CORES = 4
);
    logic [NB_CORES-1:0]        core_req_i;
    logic [NB_CORES-1:0]        core_wen_i;
    logic [NB_CORES-1:0][2:0]   core_add_i;
    logic [NB_CORES-1:0][31:0]  core_wdata_i;
    logic [NB_CORES-1:0][31:0]  core_rdata_o;

    logic                       periph_req_i;
    logic                       periph_wen_i;
    logic [2:0]                 periph_add_i;
    logic [31:0]                periph_wdata_i;
    logic                       periph_gnt_o;
    logic                       periph_r_valid_o;
    logic [31:0]                periph_r_rdata_o;

    modport slave (
        input  core_req_i, core_wen_i, core_add_i, core_wdata_i,
        output core_rdata_o,
        input  periph_req_i, periph_wen_i, periph_add_i, periph_wdata_i,
        output periph_gnt_o, periph_r_valid_o, periph_r_rdata_o
    );

    modport master (
        output core_req_i, core_wen_i, core_add_i, core_wdata_i,
        input  core_rdata_o,
        output periph_req_i, periph_wen_i, periph_add_i, periph_wdata_i,
        input  periph_gnt_o, periph_r_valid_o, periph_r_rdata_o
    );
endinterface

// File: rtl/event_unit_hw_barrier.sv
// Hardware barrier: collects per-core arrivals under TRIG_MASK and emits a one-cycle
// wake-up pulse of TARGET_MASK once every masked core has arrived.
module event_unit_hw_barrier #(
    parameter int unsigned NB_CORES = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    event_unit_hw_barrier_if.slave  bus,
    output logic [NB_CORES-1:0]     barrier_event_o
);

    localparam logic [2:0] RegTrigMask   = 3'd0;
    localparam logic [2:0] RegStatus     = 3'd1;
    localparam logic [2:0] RegTargetMask = 3'd2;
    localparam logic [2:0] RegTrigger    = 3'd3;

    typedef enum logic [1:0] {StIdle, StCollect, StFire} state_e;

    state_e                    state_q, state_d;
    logic [NB_CORES-1:0]       trig_mask_q, trig_mask_d;
    logic [NB_CORES-1:0]       target_mask_q, target_mask_d;
    logic [NB_CORES-1:0]       status_q, status_d;
    logic [NB_CORES-1:0]       arrivals;
    logic [NB_CORES-1:0]       next_status;
    logic                      trig_mask_wr;

    logic [NB_CORES-1:0][31:0] core_rdata_q, core_rdata_d;
    logic                      periph_r_valid_q;
    logic [31:0]               periph_r_rdata_q, periph_r_rdata_d;

    logic [NB_CORES-1:0]       unused_core_wdata;
    logic                      unused_periph_wdata;

    function automatic logic [31:0] read_mux(input logic [2:0]          add,
                                             input logic [NB_CORES-1:0] trig,
                                             input logic [NB_CORES-1:0] status,
                                             input logic [NB_CORES-1:0] target);
        logic [31:0] val;
        val = '0;
        case (add)
            RegTrigMask:   val[NB_CORES-1:0] = trig;
            RegStatus:     val[NB_CORES-1:0] = status;
            RegTargetMask: val[NB_CORES-1:0] = target;
            default:       val = '0;
        endcase
        return val;
    endfunction

    // Register writes and arrival collection; periph is applied last so it wins.
    always_comb begin
        trig_mask_d   = trig_mask_q;
        target_mask_d = target_mask_q;
        trig_mask_wr  = 1'b0;
        arrivals      = '0;
        for (int i = 0; i < NB_CORES; i++) begin
            if (bus.core_req_i[i] && !bus.core_wen_i[i]) begin
                case (bus.core_add_i[i])
                    RegTrigMask: begin
                        trig_mask_d  = bus.core_wdata_i[i][NB_CORES-1:0];
                        trig_mask_wr = 1'b1;
                    end
                    RegTargetMask: target_mask_d = bus.core_wdata_i[i][NB_CORES-1:0];
                    RegTrigger:    arrivals[i]   = 1'b1;
                    default: ;
                endcase
            end
        end
        if (bus.periph_req_i && !bus.periph_wen_i) begin
            case (bus.periph_add_i)
                RegTrigMask: begin
                    trig_mask_d  = bus.periph_wdata_i[NB_CORES-1:0];
                    trig_mask_wr = 1'b1;
                end
                RegTargetMask: target_mask_d = bus.periph_wdata_i[NB_CORES-1:0];
                RegTrigger:    arrivals      = arrivals | bus.periph_wdata_i[NB_CORES-1:0];
                default: ;
            endcase
        end
    end

    // Barrier FSM next state; FIRE behaves like IDLE for arrivals so rounds can chain.
    always_comb begin
        state_d         = state_q;
        status_d        = status_q;
        barrier_event_o = '0;
        next_status     = status_q | (arrivals & trig_mask_q);

        if (trig_mask_wr) begin
            status_d = '0;
            state_d  = StIdle;
        end else if ((trig_mask_q != '0) && (next_status == trig_mask_q)) begin
            status_d = '0;
            state_d  = StFire;
        end else begin
            status_d = next_status;
            state_d  = (next_status != '0) ? StCollect : StIdle;
        end

        case (state_q)
            StFire:  barrier_event_o = target_mask_q;
            default: barrier_event_o = '0;
        endcase
    end

    // Read responses see the pre-update register values of the request cycle.
    always_comb begin
        for (int i = 0; i < NB_CORES; i++) begin
            core_rdata_d[i] = '0;
            if (bus.core_req_i[i] && bus.core_wen_i[i]) begin
                core_rdata_d[i] = read_mux(bus.core_add_i[i], trig_mask_q, status_q,
                                           target_mask_q);
            end
            unused_core_wdata[i] = ^bus.core_wdata_i[i][31:NB_CORES-1];
        end
        periph_r_rdata_d = '0;
        if (bus.periph_req_i && bus.periph_wen_i) begin
            periph_r_rdata_d = read_mux(bus.periph_add_i, trig_mask_q, status_q, target_mask_q);
        end
        unused_periph_wdata = ^bus.periph_wdata_i[31:NB_CORES-1];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q          <= StIdle;
            trig_mask_q      <= '0;
            target_mask_q    <= '0;
            status_q         <= '0;
            core_rdata_q     <= '0;
            periph_r_valid_q <= 1'b0;
            periph_r_rdata_q <= '0;
        end else begin
            state_q          <= state_d;
            trig_mask_q      <= trig_mask_d;
            target_mask_q    <= target_mask_d;
            status_q         <= status_d;
            core_rdata_q     <= core_rdata_d;
            periph_r_valid_q <= bus.periph_req_i;
            periph_r_rdata_q <= periph_r_rdata_d;
        end
    end

    assign bus.core_rdata_o     = core_rdata_q;
    assign bus.periph_gnt_o     = bus.periph_req_i;
    assign bus.periph_r_valid_o = periph_r_valid_q;
    assign bus.periph_r_rdata_o = periph_r_rdata_q;

endmodule
